// File: rtl/console_pkg.sv
// Shared console definitions: TX state encoding, default console address and the
// strobe-to-character lane decoder also used by the simulation monitor.
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h01ff_fff0;

    // Returns {hit, char}; only the four whole-word strobe patterns carry a character.
    function automatic logic [8:0] lane_sel(input logic [15:0] strb, input logic [127:0] data);
        logic [8:0] res;
        res = 9'd0;
        case (strb)
            16'h000f: res = {1'b1, data[7:0]};
            16'h00f0: res = {1'b1, data[39:32]};
            16'h0f00: res = {1'b1, data[71:64]};
            16'hf000: res = {1'b1, data[103:96]};
            default:  res = 9'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/console_sync_fifo.sv
// 8-bit synchronous FIFO with registered read data; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module console_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  pop_data_reg;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign pop_data = pop_data_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
        if (do_pop) begin
            pop_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/axi_console_uart_tx.sv
// Observe-only console tap on the BIU write channel: captures console characters,
// buffers them and transmits each one as an 8N1 UART frame on uart_tx.
module axi_console_uart_tx
    import console_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          BAUD_DIV     = 868
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          wr_vld,
    input  logic [31:0]                   wr_addr,
    input  logic [3:0]                    wr_len,
    input  logic [15:0]                   wr_strb,
    input  logic [127:0]                  wr_data,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);
    localparam int             BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [8:0]      lane;
    logic            cap_vld_reg;
    logic [7:0]      cap_char_reg;
    tx_state_e       state_reg;
    logic [BW-1:0]   baud_reg;
    logic [2:0]      bit_reg;
    logic [7:0]      shift_reg;
    logic            uart_tx_reg;
    logic            tx_busy_reg;
    logic [15:0]     drop_cnt_reg;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_data;
    logic            baud_end;

    assign lane     = lane_sel(wr_strb, wr_data);
    assign fifo_pop = (state_reg == IDLE) && !fifo_empty;
    assign baud_end = (baud_reg == BAUD_LAST);

    assign uart_tx  = uart_tx_reg;
    assign tx_busy  = tx_busy_reg;
    assign drop_cnt = drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_reg <= 1'b0;
        end else begin
            cap_vld_reg <= wr_vld && clk_en && (wr_len == 4'd0) &&
                           (wr_addr == CONSOLE_ADDR) && lane[8];
        end
        cap_char_reg <= lane[7:0];
    end

    console_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_vld_reg),
        .push_data (cap_char_reg),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= 16'd0;
        end else if (cap_vld_reg && fifo_full && !fifo_pop && (drop_cnt_reg != 16'hffff)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    // uart_tx is driven from the state of the previous cycle, so the line trails the
    // FSM by one clock and the start bit falls one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_reg     <= 3'd0;
            shift_reg   <= 8'd0;
            uart_tx_reg <= 1'b1;
            tx_busy_reg <= 1'b0;
        end else begin
            tx_busy_reg <= (state_reg != IDLE) || (fifo_level != '0);
            case (state_reg)
                IDLE: begin
                    uart_tx_reg <= 1'b1;
                    baud_reg    <= '0;
                    bit_reg     <= 3'd0;
                    if (fifo_pop) state_reg <= START;
                end
                START: begin
                    uart_tx_reg <= 1'b0;
                    if (baud_end) begin
                        baud_reg  <= '0;
                        shift_reg <= fifo_data;
                        state_reg <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                DATA: begin
                    uart_tx_reg <= shift_reg[0];
                    if (baud_end) begin
                        baud_reg  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_reg == 3'd7) begin
                            bit_reg   <= 3'd0;
                            state_reg <= STOP;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                STOP: begin
                    uart_tx_reg <= 1'b1;
                    if (baud_end) begin
                        baud_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_console_uart_tx.sv
// Directed and random console traffic checked against a transaction-level model of
// character buffering, drops and frame timing, plus a UART line receiver.
module tb_axi_console_uart_tx;
    localparam int          B      = 4;
    localparam int          D      = 4;
    localparam int          PITCH  = 10 * B + 1;
    localparam int          STOP_C = 9 * B + B / 2;
    localparam logic [31:0] CADDR  = 32'h01ff_fff0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic         wr_vld = 1'b0;
    logic [31:0]  wr_addr = 32'd0;
    logic [3:0]   wr_len = 4'd0;
    logic [15:0]  wr_strb = 16'd0;
    logic [127:0] wr_data = 128'd0;
    logic         uart_tx;
    logic         tx_busy;
    logic [2:0]   fifo_level;
    logic [15:0]  drop_cnt;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct { int at; logic [7:0] ch; } ev_t;
    typedef struct { int at; logic [7:0] ch; bit ok; } rx_t;
    ev_t pend_q[$];
    ev_t fifo_q[$];
    ev_t exp_q[$];
    rx_t obs_q[$];
    int  npa = 0;
    int  m_drop = 0;

    axi_console_uart_tx #(.CONSOLE_ADDR(CADDR), .FIFO_DEPTH(D), .BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .wr_vld     (wr_vld),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_strb    (wr_strb),
        .wr_data    (wr_data),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a beat sampled on edge e enqueues a push at e+1; the line pops the oldest
    // character once it has sat a cycle and the previous frame pitch has elapsed.
    function automatic void m_beat(input int e, input logic en, input logic [31:0] addr,
                                   input logic [3:0] len, input logic [15:0] strb,
                                   input logic [127:0] data);
        logic [7:0] ch;
        bit hit;
        hit = 1;
        case (strb)
            16'h000f: ch = data[7:0];
            16'h00f0: ch = data[39:32];
            16'h0f00: ch = data[71:64];
            16'hf000: ch = data[103:96];
            default: begin hit = 0; ch = 8'h00; end
        endcase
        if (en && len == 4'd0 && addr == CADDR && hit) pend_q.push_back('{e + 1, ch});
    endfunction

    function automatic void m_advance(input int t);
        int pp;
        int pe;
        while (1) begin
            pp = (pend_q.size() != 0) ? pend_q[0].at : 32'h3fff_ffff;
            pe = (fifo_q.size() != 0) ? ((fifo_q[0].at + 1 > npa) ? fifo_q[0].at + 1 : npa)
                                      : 32'h3fff_ffff;
            if (pe <= t && pe <= pp) begin
                exp_q.push_back('{pe + 1, fifo_q[0].ch});
                npa = pe + PITCH;
                void'(fifo_q.pop_front());
            end else if (pp <= t) begin
                if (fifo_q.size() < D) fifo_q.push_back(pend_q[0]);
                else if (m_drop != 16'hffff) m_drop++;
                void'(pend_q.pop_front());
            end else begin
                break;
            end
        end
    endfunction

    function automatic void m_reset(input int r);
        m_advance(r - 1);
        fifo_q.delete();
        while (pend_q.size() != 0 && pend_q[0].at <= r + 1) void'(pend_q.pop_front());
        while (exp_q.size() != 0 && exp_q[exp_q.size() - 1].at + STOP_C >= r)
            void'(exp_q.pop_back());
        m_drop = 0;
        npa = r + 1;
    endfunction

    task automatic drive(input logic en, input logic [31:0] addr, input logic [3:0] len,
                         input logic [15:0] strb, input logic [127:0] data);
        wr_vld = 1'b1; clk_en = en; wr_addr = addr; wr_len = len; wr_strb = strb; wr_data = data;
        m_beat(cyc + 1, en, addr, len, strb, data);
        @(negedge clk);
        wr_vld = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_char(input logic [7:0] ch);
        int ln;
        logic [127:0] d;
        logic [15:0] s;
        ln = $urandom_range(0, 3);
        d = rnd128();
        d[32 * ln +: 8] = ch;
        s = 16'h000f << (4 * ln);
        drive(1'b1, CADDR, 4'd0, s, d);
    endtask

    task automatic check_model(input string tag);
        m_advance(cyc);
        check({tag, ".level"}, 32'(fifo_level), 32'(fifo_q.size()));
        check({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && (tx_busy !== 1'b0 || fifo_level !== 3'd0); i++)
            @(negedge clk);
        check({tag, ".idle"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        int r;
        rst = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        m_reset(r);
        check({tag, ".tx"}, 32'(uart_tx), 32'd1);
        check({tag, ".busy"}, 32'(tx_busy), 32'd0);
        check_model(tag);
        rst = 1'b0;
    endtask

    // Line receiver: samples mid-bit, abandons a frame cut short by reset.
    initial begin
        int f;
        logic [7:0] b;
        bit ok;
        bit aborted;
        forever begin
            @(posedge clk); #1;
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                f = cyc; b = 8'h00; ok = 1; aborted = 0;
                for (int k = 1; k <= STOP_C; k++) begin
                    @(posedge clk); #1;
                    if (rst !== 1'b0) begin aborted = 1; break; end
                    if (k == B / 2 && uart_tx !== 1'b0) ok = 0;
                    if (k >= B + B / 2 && ((k - B - B / 2) % B) == 0 && ((k - B - B / 2) / B) < 8)
                        b[(k - B - B / 2) / B] = uart_tx;
                    if (k == STOP_C && uart_tx !== 1'b1) ok = 0;
                end
                if (!aborted) obs_q.push_back('{f, b, ok});
            end
        end
    end

    initial begin
        int s;
        int gap;
        logic [127:0] d;
        logic [9:0] frame41;
        logic [15:0] strb_tab [6];
        logic en;
        logic [31:0] addr;
        logic [3:0] len;
        logic [15:0] strb;

        // Reset state
        repeat (3) @(negedge clk);
        m_reset(cyc);
        rst = 1'b0;
        check("rst.tx", 32'(uart_tx), 32'd1);
        check("rst.busy", 32'(tx_busy), 32'd0);
        check_model("rst");
        check("rst.level0", 32'(fifo_level), 32'd0);

        // 1: 'A' on lane 0, exact line waveform and latency
        s = cyc + 1;
        d = rnd128(); d[7:0] = 8'h41;
        drive(1'b1, CADDR, 4'd0, 16'h000f, d);
        wait_until(s + 2);
        check("t1.pre_fall", 32'(uart_tx), 32'd1);
        wait_until(s + 3);
        check("t1.fall", 32'(uart_tx), 32'd0);
        check("t1.busy", 32'(tx_busy), 32'd1);
        frame41 = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10; k++) begin
            wait_until(s + 3 + B * k + B / 2);
            check($sformatf("t1.bit%0d", k), 32'(uart_tx), 32'(frame41[k]));
        end
        wait_idle("t1", 200);

        // 2: lane 3 hit, then non-qualifying beats
        d = rnd128(); d[103:96] = 8'h0a;
        drive(1'b1, CADDR, 4'd0, 16'hf000, d);
        drive(1'b1, CADDR, 4'd0, 16'h00ff, rnd128());
        drive(1'b1, CADDR, 4'd1, 16'h000f, rnd128());
        drive(1'b0, CADDR, 4'd0, 16'h000f, rnd128());
        drive(1'b1, CADDR + 32'd16, 4'd0, 16'h000f, rnd128());
        wait_idle("t2", 300);
        check_model("t2");
        check("t2.drop0", 32'(drop_cnt), 32'd0);

        // 3: six back-to-back chars, one drop
        s = cyc + 1;
        for (int i = 0; i < 6; i++) send_char(8'h61 + 8'(i));
        wait_until(s + 6);
        check_model("t3");
        check("t3.drop1", 32'(drop_cnt), 32'd1);
        wait_idle("t3", 400);

        // 4: push lands on the same edge as a pop from a full FIFO
        s = cyc + 1;
        for (int i = 0; i < 5; i++) send_char(8'($urandom));
        wait_until(s + PITCH);
        check_model("t4.full");
        send_char(8'($urandom));
        wait_until(s + 2 + PITCH);
        check_model("t4.same_edge");
        check("t4.level4", 32'(fifo_level), 32'd4);
        wait_idle("t4", 400);

        // 5: reset during data bit 3 aborts the frame and flushes the FIFO
        s = cyc + 1;
        for (int i = 0; i < 3; i++) send_char(8'($urandom));
        wait_until(s + 19);
        pulse_reset("t5");
        repeat (60) @(negedge clk);
        check("t5.no_frame", 32'(obs_q.size()), 32'(exp_q.size()));
        send_char(8'($urandom));
        wait_idle("t5", 200);

        // Random traffic with mixed qualifiers and gaps
        strb_tab[0] = 16'h000f; strb_tab[1] = 16'h00f0; strb_tab[2] = 16'h0f00;
        strb_tab[3] = 16'hf000; strb_tab[4] = 16'h00ff; strb_tab[5] = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 12);
            repeat (gap) @(negedge clk);
            en   = ($urandom_range(0, 9) != 0);
            addr = ($urandom_range(0, 7) != 0) ? CADDR : $urandom;
            len  = ($urandom_range(0, 7) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
            strb = strb_tab[$urandom_range(0, 5)];
            drive(en, addr, len, strb, rnd128());
            if ((i % 10) == 9) check_model($sformatf("rnd%0d", i));
        end
        wait_idle("rnd", 800);
        check_model("rnd.end");

        // 6: drop counter saturation
        force dut.drop_cnt_reg = 16'hfffe;
        @(negedge clk);
        release dut.drop_cnt_reg;
        m_advance(cyc);
        m_drop = 16'hfffe;
        check_model("t6.forced");
        for (int i = 0; i < 8; i++) send_char(8'($urandom));
        repeat (3) @(negedge clk);
        check_model("t6.sat");
        check("t6.ffff", 32'(drop_cnt), 32'h0000_ffff);
        wait_idle("t6", 400);

        // Scoreboard: every modelled frame seen on the line at the modelled time
        repeat (5) @(negedge clk);
        m_advance(cyc);
        check("sb.count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("sb.char%0d", i), 32'(obs_q[i].ch), 32'(exp_q[i].ch));
            check($sformatf("sb.fall%0d", i), 32'(obs_q[i].at), 32'(exp_q[i].at));
            check($sformatf("sb.frame%0d", i), 32'(obs_q[i].ok), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
